// File: rtl/rv_pkg.sv
// Shared pipeline-selector types: FSM state encoding and a default-width entry.
// No logic; consumed by pipe_mux and pipe_mux_sel.
// No backpressure concerns at package level.
package rv_pkg;

    localparam int PMUX_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        PMUX_EMPTY = 2'd0,
        PMUX_FULL  = 2'd1,
        PMUX_SKID  = 2'd2
    } pmux_state_t;

    typedef struct packed {
        logic [PMUX_WIDTH_DEF-1:0] data;
        logic                      err;
    } pmux_entry_t;

endpackage

// File: rtl/pipe_mux_sel.sv
// Indexed slice of a packed input vector with an out-of-range flag.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module pipe_mux_sel
    import rv_pkg::*;
#(
    parameter int WIDTH  = PMUX_WIDTH_DEF,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        data,
    output logic                    err
);

    // Out-of-range selects yield zero data and raise err.
    always_comb begin
        data = '0;
        err  = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                data = in_data[i*WIDTH +: WIDTH];
                err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipe_mux.sv
// Registered N-to-1 selector with valid/ready handshake and a one-entry skid buffer.
// Latency: one cycle from accept to out_valid; one transfer per cycle sustained.
// Backpressure: in_ready is registered (low only while the skid entry is held).
module pipe_mux
    import rv_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             err;
    } entry_t;

    pmux_state_t state_q, state_d;
    entry_t      out_q, skd_q, sel_ent;
    logic        in_rdy_q;
    logic        accept, emit;
    logic        load_out, load_skd, out_from_skd;
    logic [WIDTH-1:0] sel_data;
    logic        sel_err;

    pipe_mux_sel #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_sel (
        .in_data (in_data),
        .sel     (in_sel),
        .data    (sel_data),
        .err     (sel_err)
    );

    assign sel_ent   = '{data: sel_data, err: sel_err};
    assign in_ready  = in_rdy_q;
    assign out_valid = (state_q != PMUX_EMPTY);
    assign out_data  = out_q.data;
    assign out_err   = out_q.err;
    assign accept    = in_valid && in_rdy_q;
    assign emit      = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= PMUX_EMPTY;
            in_rdy_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            // Registered copy of "skid slot free" keeps out_ready off the in_ready path.
            in_rdy_q <= (state_d != PMUX_SKID);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PMUX_EMPTY: if (accept) state_d = PMUX_FULL;
            PMUX_FULL: begin
                if (emit && !accept)      state_d = PMUX_EMPTY;
                else if (!emit && accept) state_d = PMUX_SKID;
            end
            PMUX_SKID:  if (emit) state_d = PMUX_FULL;
            default:    state_d = PMUX_EMPTY;
        endcase
        if (flush) state_d = PMUX_EMPTY;
    end

    always_comb begin
        load_out     = 1'b0;
        load_skd     = 1'b0;
        out_from_skd = 1'b0;
        case (state_q)
            PMUX_EMPTY: load_out = accept;
            PMUX_FULL: begin
                load_out = emit && accept;
                load_skd = !emit && accept;
            end
            PMUX_SKID: begin
                load_out     = emit;
                out_from_skd = 1'b1;
            end
            default: ;
        endcase
        // Flush discards everything, including any same-cycle accept.
        if (flush) begin
            load_out = 1'b0;
            load_skd = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            skd_q <= '0;
        end else begin
            if (load_out) out_q <= out_from_skd ? skd_q : sel_ent;
            if (load_skd) skd_q <= sel_ent;
        end
    end

endmodule

// File: tb/tb_pipe_mux.sv
// Directed + random-soak bench for pipe_mux with a queue scoreboard on the NUM_IN=4 instance.
// A second NUM_IN=3 instance exercises the out-of-range select path.
module tb_pipe_mux;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] in_data;
    logic [1:0]   in_sel;
    logic         in_valid, in_ready, flush;
    logic [31:0]  out_data;
    logic         out_err, out_valid, out_ready;

    logic [95:0]  in_data3;
    logic [1:0]   in_sel3;
    logic         in_valid3, in_ready3, flush3;
    logic [31:0]  out_data3;
    logic         out_err3, out_valid3, out_ready3;

    int n_assert = 0;
    int n_fail   = 0;
    logic [32:0] sb_q[$];
    logic        hold;
    logic [32:0] hold_val;

    always #5 clk = ~clk;

    pipe_mux #(.WIDTH(32), .NUM_IN(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .out_data(out_data), .out_err(out_err), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    pipe_mux #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_sel(in_sel3),
        .in_valid(in_valid3), .in_ready(in_ready3), .flush(flush3),
        .out_data(out_data3), .out_err(out_err3), .out_valid(out_valid3),
        .out_ready(out_ready3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [127:0] d, input logic [1:0] s);
        logic [31:0] v;
        case (s)
            2'd0: v = d[31:0];
            2'd1: v = d[63:32];
            2'd2: v = d[95:64];
            default: v = d[127:96];
        endcase
        return {1'b0, v};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: inputs are driven at posedge+1, so negedge values are what the next edge sees.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            hold = 1'b0;
        end else begin
            if (hold && out_valid) chk("hold_stable", {31'b0, out_err, out_data}, {31'b0, hold_val});
            hold     = out_valid && !out_ready && !flush;
            hold_val = {out_err, out_data};
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
                end else begin
                    logic [32:0] e;
                    e = sb_q.pop_front();
                    chk("sb_out", {31'b0, out_err, out_data}, {31'b0, e});
                end
            end
            if (flush) sb_q.delete();
            else if (in_valid && in_ready) sb_q.push_back(model(in_data, in_sel));
        end
    end

    initial begin
        rst_n = 1'b0; in_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        in_sel = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_data3 = {32'h33333333, 32'h22222222, 32'h11111111};
        in_sel3 = '0; in_valid3 = 1'b0; flush3 = 1'b0; out_ready3 = 1'b1;
        hold = 1'b0; hold_val = '0;

        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_err",   64'(out_err),   64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid3", 64'(out_valid3), 64'd0);
        @(posedge clk); #3; rst_n = 1'b1;
        step();

        // Select sweep, back-to-back
        in_valid = 1'b1;
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            step();
            chk("sweep_valid", 64'(out_valid), 64'd1);
            chk("sweep_data",  64'(out_data),  64'(32'h11111111 * (s + 1)));
            chk("sweep_ready", 64'(in_ready),  64'd1);
        end
        in_valid = 1'b0;
        step();
        chk("sweep_drained", 64'(out_valid), 64'd0);

        // Out-of-range on the 3-input instance
        in_valid3 = 1'b1; in_sel3 = 2'd3;
        step();
        chk("oor_valid", 64'(out_valid3), 64'd1);
        chk("oor_data",  64'(out_data3),  64'd0);
        chk("oor_err",   64'(out_err3),   64'd1);
        in_sel3 = 2'd2;
        step();
        chk("inr_data", 64'(out_data3), 64'h33333333);
        chk("inr_err",  64'(out_err3),  64'd0);
        in_valid3 = 1'b0;
        step();
        chk("oor_drained", 64'(out_valid3), 64'd0);

        // Back-pressure into the skid slot
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd0;
        step();
        chk("bp_ready_full", 64'(in_ready), 64'd1);
        in_sel = 2'd1;
        step();
        chk("bp_ready_skid", 64'(in_ready), 64'd0);
        chk("bp_hold_a",     64'(out_data), 64'h11111111);
        in_valid = 1'b0;
        step();
        chk("bp_hold_a2",    64'(out_data), 64'h11111111);
        out_ready = 1'b1;
        step();
        chk("bp_b",          64'(out_data), 64'h22222222);
        chk("bp_ready_back", 64'(in_ready), 64'd1);
        step();
        chk("bp_empty",      64'(out_valid), 64'd0);

        // Flush in SKID with a pending input
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd2;
        step();
        in_sel = 2'd3;
        step();
        chk("fl_in_skid", 64'(in_ready), 64'd0);
        flush = 1'b1; in_sel = 2'd0;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_ready", 64'(in_ready),  64'd1);
        out_ready = 1'b1;
        step();
        chk("fl_stays_empty", 64'(out_valid), 64'd0);

        // Flush in FULL with an accept the same cycle: that entry must vanish
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd1;
        step();
        flush = 1'b1; in_sel = 2'd2;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flf_valid", 64'(out_valid), 64'd0);
        step();
        chk("flf_still_empty", 64'(out_valid), 64'd0);

        // Asynchronous reset while in SKID
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd3;
        step();
        in_sel = 2'd2;
        step();
        in_valid = 1'b0;
        chk("ar_pre_ready", 64'(in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_ready", 64'(in_ready),  64'd1);
        chk("ar_data",  64'(out_data),  64'd0);
        step();
        rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_sel = 2'd1;
        step();
        in_valid = 1'b0;
        chk("ar_resume_valid", 64'(out_valid), 64'd1);
        chk("ar_resume_data",  64'(out_data),  64'h22222222);
        step();

        // Random soak
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_sel    = 2'($urandom_range(0, 3));
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            flush     = ($urandom_range(0, 299) == 0);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 50 && (out_valid || sb_q.size() != 0); c++) step();
        chk("soak_drain_valid", 64'(out_valid),   64'd0);
        chk("soak_drain_sb",    64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
